// File: rtl/sm4_key_expand.sv
`default_nettype none
// ============================================================================
//  Module   : sm4_key_expand (with helper sm4_sbox)
//  Purpose  : Iterative SM4 key schedule, one round key per clock into a
//             32-entry register file with forward/reverse read port.
//             Define SM4_KEYEXP_REGOUT_EN for a registered read port.
//  Revision : 1.0 - initial release
// ============================================================================

module sm4_sbox (
    input  logic [7:0] din_i,
    output logic [7:0] dout_o
);
    localparam logic [2047:0] c_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Entry 0 sits in the top byte, so entry n starts at bit 8*(255-n).
    assign dout_o = c_SBOX[{~din_i, 3'b000} +: 8];
endmodule

module sm4_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid_in,
    input  logic [127:0] key_in,
    output logic         key_ready_out,
    output logic         busy_out,
    output logic         keys_valid_out,
    input  logic [4:0]   rk_idx_in,
    input  logic         rk_dec_in,
    output logic [31:0]  rk_out
);
    localparam logic [31:0] c_FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] c_FK1 = 32'h56AA3350;
    localparam logic [31:0] c_FK2 = 32'h677D9197;
    localparam logic [31:0] c_FK3 = 32'hB27022DC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] k0_q, k1_q, k2_q, k3_q;
    logic [31:0] k0_d, k1_d, k2_d, k3_d;
    logic        kv_q, kv_d;
    logic [31:0] rf_q [32];

    logic        w_accept, w_we;
    logic [31:0] w_ck, w_x, w_b, w_rk;
    logic [4:0]  w_ridx;

    assign key_ready_out = (state_q != ST_EXPAND);
    assign busy_out      = (state_q == ST_EXPAND);
    assign w_accept      = key_valid_in && key_ready_out;

    // CK byte j of round i is (4i+j)*7 mod 256; an 8-bit product wraps for free.
    generate
        for (genvar j = 0; j < 4; j++) begin : g_ck
            localparam logic [1:0] c_J = 2'(j);
            logic [7:0] w_prod;
            assign w_prod            = {1'b0, cnt_q, c_J} * 8'd7;
            assign w_ck[31-8*j -: 8] = w_prod;
        end
    endgenerate

    assign w_x = k1_q ^ k2_q ^ k3_q ^ w_ck;

    generate
        for (genvar j = 0; j < 4; j++) begin : g_sbox
            sm4_sbox u_sbox (
                .din_i  (w_x[31-8*j -: 8]),
                .dout_o (w_b[31-8*j -: 8])
            );
        end
    endgenerate

    assign w_rk = k0_q ^ w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        kv_d    = kv_q;
        w_we    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    state_d = ST_EXPAND;
                    cnt_d   = 5'd0;
                    k0_d    = key_in[127:96] ^ c_FK0;
                    k1_d    = key_in[95:64]  ^ c_FK1;
                    k2_d    = key_in[63:32]  ^ c_FK2;
                    k3_d    = key_in[31:0]   ^ c_FK3;
                    kv_d    = 1'b0;
                end
            end
            ST_EXPAND: begin
                w_we  = 1'b1;
                k0_d  = k1_q;
                k1_d  = k2_q;
                k2_d  = k3_q;
                k3_d  = w_rk;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                    kv_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            k0_q    <= 32'h0;
            k1_q    <= 32'h0;
            k2_q    <= 32'h0;
            k3_q    <= 32'h0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
            kv_q    <= kv_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 32; n++) rf_q[n] <= 32'h0;
        end else if (w_we) begin
            rf_q[cnt_q] <= w_rk;
        end
    end

    assign w_ridx = rk_dec_in ? (5'd31 - rk_idx_in) : rk_idx_in;

`ifdef SM4_KEYEXP_REGOUT_EN
    // Valid is delayed alongside the data so the pair stays aligned.
    logic [31:0] rk_q;
    logic        kvo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_q  <= 32'h0;
            kvo_q <= 1'b0;
        end else begin
            rk_q  <= kv_q ? rf_q[w_ridx] : 32'h0;
            kvo_q <= kv_q;
        end
    end

    assign rk_out         = rk_q;
    assign keys_valid_out = kvo_q;
`else
    assign rk_out         = kv_q ? rf_q[w_ridx] : 32'h0;
    assign keys_valid_out = kv_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_sm4_key_expand.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm4_key_expand
//  Purpose  : Self-checking bench for sm4_key_expand (directed + random keys).
//  Revision : 1.0 - initial release
// ============================================================================

module tb_sm4_key_expand;
    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid_in;
    logic [127:0] key_in;
    logic         key_ready_out;
    logic         busy_out;
    logic         keys_valid_out;
    logic [4:0]   rk_idx_in;
    logic         rk_dec_in;
    logic [31:0]  rk_out;

    always #5 clk = ~clk;

    sm4_key_expand dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid_in   (key_valid_in),
        .key_in         (key_in),
        .key_ready_out  (key_ready_out),
        .busy_out       (busy_out),
        .keys_valid_out (keys_valid_out),
        .rk_idx_in      (rk_idx_in),
        .rk_dec_in      (rk_dec_in),
        .rk_out         (rk_out)
    );

`ifdef SM4_KEYEXP_REGOUT_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    localparam logic [127:0] c_STD = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] c_KB  = 128'h000102030405060708090A0B0C0D0E0F;

    localparam logic [2047:0] c_SB = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rk [32];

    typedef struct {
        logic        dec;
        logic [4:0]  idx;
        logic [31:0] req;
    } vec_t;
    vec_t vt [6];

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        return c_SB[2047 - 8*int'(x) -: 8];
    endfunction

    // Software key schedule for one master key.
    task automatic model(input logic [127:0] mk);
        logic [31:0] k [4];
        logic [31:0] ck, x, b, rk;
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            x = k[1] ^ k[2] ^ k[3] ^ ck;
            for (int j = 0; j < 4; j++) b[31-8*j -: 8] = sbox_f(x[31-8*j -: 8]);
            rk = k[0] ^ b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
            exp_rk[i] = rk;
            k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = rk;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic rd(input string nm, input logic dec, input logic [4:0] idx,
                      input logic [31:0] req);
        @(negedge clk);
        rk_dec_in = dec;
        rk_idx_in = idx;
`ifdef SM4_KEYEXP_REGOUT_EN
        @(posedge clk);
`endif
        #1;
        chk(nm, rk_out, req);
    endtask

    task automatic load_key(input logic [127:0] mk);
        @(negedge clk);
        key_in       = mk;
        key_valid_in = 1'b1;
        @(posedge clk);
        #1;
        key_valid_in = 1'b0;
    endtask

    task automatic wait_kv(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!keys_valid_out && n < 40);
    endtask

    initial begin
        int n;
        int cyc;
        logic [127:0] k, knext;
        logic [4:0]   ix;
        logic         dc;

        vt[0] = '{1'b0, 5'd0,  32'hF12186F9};
        vt[1] = '{1'b0, 5'd1,  32'h41662B61};
        vt[2] = '{1'b0, 5'd31, 32'h9124A012};
        vt[3] = '{1'b1, 5'd0,  32'h9124A012};
        vt[4] = '{1'b1, 5'd31, 32'hF12186F9};
        vt[5] = '{1'b1, 5'd30, 32'h41662B61};

        rst = 1'b0; key_valid_in = 1'b0; key_in = '0; rk_idx_in = '0; rk_dec_in = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", 32'(key_ready_out), 32'd1);
        chk("rst_busy",  32'(busy_out), 32'd0);
        chk("rst_kv",    32'(keys_valid_out), 32'd0);
        chk("rst_rk",    rk_out, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        rd("pre_valid_rd", 1'b0, 5'd7, 32'h0);

        // Standard vector and latency
        load_key(c_STD);
        chk("e0_busy",  32'(busy_out), 32'd1);
        chk("e0_ready", 32'(key_ready_out), 32'd0);
        chk("e0_kv",    32'(keys_valid_out), 32'd0);
        wait_kv(n);
        chk("kv_latency", 32'(n), 32'(LAT));
        chk("done_busy",  32'(busy_out), 32'd0);
        chk("done_ready", 32'(key_ready_out), 32'd1);

        for (int v = 0; v < 6; v++) rd("std_table", vt[v].dec, vt[v].idx, vt[v].req);

        model(c_STD);
        chk("model_rk0", exp_rk[0], 32'hF12186F9);
        for (int i = 0; i < 32; i++) rd("std_enc_sweep", 1'b0, 5'(i), exp_rk[i]);
        for (int i = 0; i < 32; i++) rd("std_dec_sweep", 1'b1, 5'(i), exp_rk[31-i]);

        // Key B offered during EXPAND must wait for DONE
        load_key(c_STD);
        repeat (5) @(posedge clk);
        @(negedge clk);
        key_in = c_KB; key_valid_in = 1'b1; rk_idx_in = 5'd0; rk_dec_in = 1'b0;
        for (int e = 6; e <= 31; e++) begin
            @(posedge clk); #1;
            chk("ready_in_expand", 32'(key_ready_out), 32'd0);
        end
        @(posedge clk); #1;
        chk("e32_ready", 32'(key_ready_out), 32'd1);
`ifdef SM4_KEYEXP_REGOUT_EN
        chk("e32_kv", 32'(keys_valid_out), 32'd0);
`else
        chk("e32_kv", 32'(keys_valid_out), 32'd1);
        chk("e32_rk_a", rk_out, 32'hF12186F9);
`endif
        @(posedge clk); #1;
        key_valid_in = 1'b0;
        chk("e33_ready", 32'(key_ready_out), 32'd0);
        chk("e33_busy",  32'(busy_out), 32'd1);
`ifdef SM4_KEYEXP_REGOUT_EN
        chk("e33_kv", 32'(keys_valid_out), 32'd1);
        chk("e33_rk_a", rk_out, 32'hF12186F9);
`else
        chk("e33_kv", 32'(keys_valid_out), 32'd0);
`endif
        wait_kv(n);
        chk("kv_latency_b", 32'(n), 32'(LAT));
        model(c_KB);
        for (int i = 0; i < 32; i++) rd("keyb_sweep", 1'b0, 5'(i), exp_rk[i]);

        // Asynchronous reset in the middle of expansion
        load_key(c_STD);
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(key_ready_out), 32'd1);
        chk("midrst_busy",  32'(busy_out), 32'd0);
        chk("midrst_kv",    32'(keys_valid_out), 32'd0);
        chk("midrst_rk",    rk_out, 32'h0);
        @(negedge clk) rst = 1'b0;
        rd("post_rst_rd", 1'b0, 5'd3, 32'h0);
        load_key(c_STD);
        wait_kv(n);
        chk("rerun_latency", 32'(n), 32'(LAT));
        rd("rerun_rk0", 1'b0, 5'd0, 32'hF12186F9);
        rd("rerun_rk31", 1'b0, 5'd31, 32'h9124A012);

        // Random keys, back-to-back with valid held high
        @(negedge clk);
        k = {$urandom, $urandom, $urandom, $urandom};
        key_in = k; key_valid_in = 1'b1;
        for (int r = 0; r < 1000; r++) begin
            model(k);
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
            end while (!key_ready_out && cyc < 40);
`ifdef SM4_KEYEXP_REGOUT_EN
            chk("b2b_period", 32'(cyc), (r == 0) ? 32'd33 : 32'd32);
            ix = 5'($urandom_range(0, 31));
            dc = 1'($urandom_range(0, 1));
            rk_idx_in = ix; rk_dec_in = dc;
            knext = {$urandom, $urandom, $urandom, $urandom};
            key_in = knext;
            @(posedge clk); #1;
            chk("rand_kv", 32'(keys_valid_out), 32'd1);
            chk("rand_rk", rk_out, dc ? exp_rk[31-ix] : exp_rk[ix]);
            k = knext;
`else
            chk("b2b_period", 32'(cyc), 32'd33);
            chk("rand_kv", 32'(keys_valid_out), 32'd1);
            for (int q = 0; q < 3; q++) begin
                ix = 5'($urandom_range(0, 31));
                dc = 1'($urandom_range(0, 1));
                rk_idx_in = ix; rk_dec_in = dc;
                #1;
                chk("rand_rk", rk_out, dc ? exp_rk[31-ix] : exp_rk[ix]);
            end
            k = {$urandom, $urandom, $urandom, $urandom};
            key_in = k;
`endif
        end
        key_valid_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
